// File: rtl/outbox_fifo.sv
// OUTBOX buffer between the control unit and an external consumer: captures R on
// each wO strobe, drains first-word-fall-through over valid/ready, back-pressures the CU.
module outbox_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic                   clk,
   input  logic                   i_rst_n,
   input  logic                   wO,
   input  logic [DATA_W-1:0]      data_in,
   input  logic                   clear,
   output logic                   outFull,
   output logic [DATA_W-1:0]      o_data,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop;

   // Flags decode the registered count only, so the CU never sees a path from its own wO.
   assign outFull = (count == FULL_CNT);
   assign o_valid = (count != '0);
   assign o_count = count;

   // clear outranks both events; a wO alongside it is simply dropped.
   assign push = wO & ~outFull & ~clear;
   assign pop  = o_valid & i_ready & ~clear;

   assign o_data = o_valid ? mem[rd_ptr] : '0;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
      end else if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (wO && outFull) o_overflow <= 1'b1;
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; o_data is masked by o_valid, so stale entries are invisible.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

endmodule

// File: tb/tb_outbox_fifo.sv
// Bench for outbox_fifo: a queue model checked every cycle plus directed
// scenarios with hand-computed expectations.
module tb_outbox_fifo;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              wO = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic              clear = 1'b0;
   logic              i_ready = 1'b0;
   logic              outFull;
   logic [DATA_W-1:0] o_data;
   logic              o_valid;
   logic [3:0]        o_count;
   logic              o_overflow;

   int n_pass = 0;
   int n_total = 0;

   outbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .i_rst_n(rst_n), .wO(wO), .data_in(data_in), .clear(clear),
      .outFull(outFull), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
      .o_count(o_count), .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: a plain queue updated from the rules for push, pop, overflow and clear.
   logic [DATA_W-1:0] mq[$];
   bit                m_ovf;
   bit                m_full;
   bit                m_valid;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_ovf = 1'b0;
      end else if (clear) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         m_full  = (mq.size() == DEPTH);
         m_valid = (mq.size() != 0);
         if (wO && m_full) m_ovf = 1'b1;
         if (m_valid && i_ready) void'(mq.pop_front());
         if (wO && !m_full) mq.push_back(data_in);
      end
   end

   always @(negedge clk) begin
      check("model_count", 32'(o_count), 32'(mq.size()));
      check("model_valid", 32'(o_valid), 32'(mq.size() != 0));
      check("model_full", 32'(outFull), 32'(mq.size() == DEPTH));
      check("model_overflow", 32'(o_overflow), 32'(m_ovf));
      if (mq.size() != 0) check("model_data", 32'(o_data), 32'(mq[0]));
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic w, input logic [DATA_W-1:0] d, input logic rdy, input logic clr);
      wO = w;
      data_in = d;
      i_ready = rdy;
      clear = clr;
   endtask

   task automatic fill(input int n, input logic [DATA_W-1:0] base);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, base + DATA_W'(i), 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic drain_expect(input int n, input logic [DATA_W-1:0] base, input string name);
      for (int i = 0; i < n; i++) begin
         check(name, 32'(o_data), 32'(base + DATA_W'(i)));
         drive(1'b0, '0, 1'b1, 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 1: async reset mid-stream with three entries held
      fill(3, 8'h31);
      check("pre_reset_count", 32'(o_count), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      check("rst_count", 32'(o_count), 32'd0);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_full", 32'(outFull), 32'd0);
      check("rst_overflow", 32'(o_overflow), 32'd0);
      check("rst_data", 32'(o_data), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // 2: fill to full, then drain in order
      fill(8, 8'h11);
      check("fill_count", 32'(o_count), 32'd8);
      check("fill_full", 32'(outFull), 32'd1);
      check("fill_head", 32'(o_data), 32'h11);
      drain_expect(8, 8'h11, "drain_order");
      check("drain_empty", 32'(o_valid), 32'd0);

      // 3: alternating push/pop across several pointer wraps
      for (int v = 0; v < 20; v++) begin
         drive(1'b1, DATA_W'(v), 1'b0, 1'b0);
         tick();
         check("wrap_data", 32'(o_data), 32'(v));
         check("wrap_count_max", 32'(o_count <= 4'd1), 32'd1);
         drive(1'b0, '0, 1'b1, 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      check("wrap_no_overflow", 32'(o_overflow), 32'd0);
      check("wrap_empty", 32'(o_count), 32'd0);

      // 4: write while full with a simultaneous pop
      fill(8, 8'h11);
      drive(1'b1, 8'hAA, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      check("full_wr_count", 32'(o_count), 32'd7);
      check("full_wr_overflow", 32'(o_overflow), 32'd1);
      check("full_wr_head", 32'(o_data), 32'h12);
      check("full_wr_notfull", 32'(outFull), 32'd0);
      drain_expect(7, 8'h12, "full_wr_drain");
      check("full_wr_empty", 32'(o_valid), 32'd0);

      // 5: write into empty with ready high, no same-cycle bypass
      drive(1'b1, 8'h5C, 1'b1, 1'b0);
      #1 check("empty_wr_same_cycle", 32'(o_valid), 32'd0);
      tick();
      check("empty_wr_valid", 32'(o_valid), 32'd1);
      check("empty_wr_data", 32'(o_data), 32'h5C);
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      check("empty_wr_popped", 32'(o_valid), 32'd0);

      // full + pop only, then DEPTH-1 with push and pop together
      fill(8, 8'h40);
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
      check("full_pop_count", 32'(o_count), 32'd7);
      check("full_pop_notfull", 32'(outFull), 32'd0);
      drive(1'b1, 8'h48, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      check("d1_pushpop_count", 32'(o_count), 32'd7);
      check("d1_pushpop_head", 32'(o_data), 32'h42);
      drain_expect(7, 8'h42, "d1_drain");

      // 6: clear with five entries and a concurrent write (overflow still set from step 4)
      fill(5, 8'h60);
      check("pre_clear_overflow", 32'(o_overflow), 32'd1);
      drive(1'b1, 8'h77, 1'b0, 1'b1);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      check("clear_count", 32'(o_count), 32'd0);
      check("clear_valid", 32'(o_valid), 32'd0);
      check("clear_overflow", 32'(o_overflow), 32'd0);
      tick();
      check("clear_wr_dropped", 32'(o_count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
